// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage issue/result controller wrapped around a
// combinational RV32I ALU; decodes, drives the ALU, resolves branches.
module alu_issue_ctrl #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    input  logic [WORD_LENGTH-1:0] rs1_data,
    input  logic [WORD_LENGTH-1:0] rs2_data,
    output logic [WORD_LENGTH-1:0] alu_in_1,
    output logic [WORD_LENGTH-1:0] alu_in_2,
    output logic                   alu_cin,
    output logic [3:0]             alu_op,
    input  logic [WORD_LENGTH-1:0] alu_out,
    input  logic                   alu_zero,
    input  logic                   alu_sign,
    input  logic                   alu_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] wb_data,
    output logic                   wb_en,
    output logic [4:0]             rd_addr,
    output logic                   is_branch,
    output logic                   branch_taken,
    output logic                   illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // funct3 to ALU op; alt selects arithmetic right shift
    function automatic logic [3:0] fn_op(input logic [2:0] fn3,
                                         input logic alt);
        unique case (fn3)
            3'b000: fn_op = ALU_ADD;
            3'b001: fn_op = ALU_SLL;
            3'b010: fn_op = ALU_SLT;
            3'b011: fn_op = ALU_SLTU;
            3'b100: fn_op = ALU_XOR;
            3'b101: fn_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: fn_op = ALU_OR;
            3'b111: fn_op = ALU_AND;
        endcase
    endfunction

    logic [WORD_LENGTH-1:0] d_in_1, d_in_2;
    logic [3:0] d_op;
    logic d_cin, d_wb, d_br, d_ill;

    logic s1_valid, s1_wb, s1_br, s1_ill;
    logic [4:0] s1_rd;
    logic [2:0] s1_f3;
    logic [2:0] s2_flags;
    logic s2_free, s1_adv, accept, taken;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    // Decode instruction into ALU controls; illegal ones become a zero add
    always_comb begin
        d_in_1 = '0;
        d_in_2 = '0;
        d_op   = ALU_ADD;
        d_cin  = 1'b0;
        d_wb   = 1'b0;
        d_br   = 1'b0;
        d_ill  = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                d_ill  = !(f7 == 7'h00 ||
                           (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                d_in_1 = rs1_data;
                d_in_2 = rs2_data;
                d_op   = fn_op(f3, f7[5]);
                d_cin  = (f3 == 3'b000) && f7[5];
                d_wb   = (rd != 5'd0);
            end
            OPC_OP_IMM: begin
                d_ill  = (f3 == 3'b001 && f7 != 7'h00) ||
                         (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
                d_in_1 = rs1_data;
                d_in_2 = {{20{instr[31]}}, instr[31:20]};
                d_op   = fn_op(f3, f7[5]);
                d_wb   = (rd != 5'd0);
            end
            OPC_LUI: begin
                d_ill  = 1'b0;
                d_in_2 = {instr[31:12], 12'b0};
                d_wb   = (rd != 5'd0);
            end
            OPC_BRANCH: begin
                d_ill  = (f3 == 3'b010) || (f3 == 3'b011);
                d_in_1 = rs1_data;
                d_in_2 = rs2_data;
                d_br   = 1'b1;
                d_cin  = (f3 == 3'b000) || (f3 == 3'b001);
                d_op   = f3[1] ? ALU_SLTU : (f3[2] ? ALU_SLT : ALU_ADD);
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_in_1 = '0;
            d_in_2 = '0;
            d_op   = ALU_ADD;
            d_cin  = 1'b0;
            d_wb   = 1'b0;
            d_br   = 1'b0;
        end
    end

    // Issue stage: hold ALU controls until the result stage can take them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            alu_in_1 <= '0;
            alu_in_2 <= '0;
            alu_cin  <= 1'b0;
            alu_op   <= ALU_ADD;
            s1_wb    <= 1'b0;
            s1_br    <= 1'b0;
            s1_ill   <= 1'b0;
            s1_rd    <= 5'd0;
            s1_f3    <= 3'd0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (accept) begin
                alu_in_1 <= d_in_1;
                alu_in_2 <= d_in_2;
                alu_cin  <= d_cin;
                alu_op   <= d_op;
                s1_wb    <= d_wb;
                s1_br    <= d_br;
                s1_ill   <= d_ill;
                s1_rd    <= rd;
                s1_f3    <= f3;
            end
        end
    end

    // Branch condition from the ALU result of the issuing instruction
    always_comb begin
        taken = 1'b0;
        if (s1_br) begin
            unique case (s1_f3)
                3'b000:         taken = alu_zero;
                3'b001:         taken = !alu_zero;
                3'b100, 3'b110: taken = alu_out[0];
                3'b101, 3'b111: taken = !alu_out[0];
                default:        taken = 1'b0;
            endcase
        end
    end

    // Result stage: capture ALU output, hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            wb_data      <= '0;
            wb_en        <= 1'b0;
            rd_addr      <= 5'd0;
            is_branch    <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            s2_flags     <= 3'd0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            wb_data      <= alu_out;
            wb_en        <= s1_wb;
            rd_addr      <= s1_rd;
            is_branch    <= s1_br;
            branch_taken <= taken;
            illegal      <= s1_ill;
            s2_flags     <= {alu_sign, alu_carry, alu_zero};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s2_flags, instr[19:15]};
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with a behavioural ALU and
// checks every result against an ISA-level scoreboard.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] alu_in_1, alu_in_2;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero, alu_sign, alu_carry;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] wb_data;
    logic        wb_en;
    logic [4:0]  rd_addr;
    logic        is_branch, branch_taken, illegal;

    alu_issue_ctrl #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_en(wb_en), .rd_addr(rd_addr),
        .is_branch(is_branch), .branch_taken(branch_taken),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: in_2 inverted under cin for every op
    logic [31:0] alu_b;
    logic [32:0] alu_sum;
    always_comb begin
        alu_b     = alu_cin ? ~alu_in_2 : alu_in_2;
        alu_sum   = {1'b0, alu_in_1} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_out   = alu_sum[31:0];
                alu_carry = alu_sum[32];
            end
            4'd1: alu_out = alu_in_1 << alu_b[4:0];
            4'd2: alu_out = {31'd0, $signed(alu_in_1) < $signed(alu_b)};
            4'd3: alu_out = {31'd0, alu_in_1 < alu_b};
            4'd4: alu_out = alu_in_1 ^ alu_b;
            4'd5: alu_out = alu_in_1 >> alu_b[4:0];
            4'd6: alu_out = $signed(alu_in_1) >>> alu_b[4:0];
            4'd7: alu_out = alu_in_1 | alu_b;
            4'd8: alu_out = alu_in_1 & alu_b;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
        alu_sign = alu_out[31];
    end

    typedef struct packed {
        logic [31:0] data;
        logic        wb;
        logic [4:0]  rd;
        logic        br;
        logic        tk;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] arith(input logic [2:0] fn3,
                                          input logic alt,
                                          input logic is_reg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (fn3)
            3'd0: if (is_reg && alt) r = a - b; else r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // ISA-level reference for one instruction
    function automatic exp_t ref_exec(input logic [31:0] i,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        exp_t e;
        logic [31:0] imm;
        logic [6:0] fn7;
        logic [2:0] fn3;
        imm = {{20{i[31]}}, i[31:20]};
        fn7 = i[31:25];
        fn3 = i[14:12];
        e = '0;
        e.rd = i[11:7];
        e.ill = 1'b1;
        case (i[6:0])
            7'b0110011: begin
                e.ill = !(fn7 == 7'h00 ||
                          (fn7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5)));
                e.data = arith(fn3, fn7 == 7'h20, 1'b1, a, b);
            end
            7'b0010011: begin
                e.ill = (fn3 == 3'd1 && fn7 != 7'h00) ||
                        (fn3 == 3'd5 && fn7 != 7'h00 && fn7 != 7'h20);
                e.data = arith(fn3, fn7 == 7'h20, 1'b0, a, imm);
            end
            7'b0110111: begin
                e.ill = 1'b0;
                e.data = {i[31:12], 12'h000};
            end
            7'b1100011: begin
                e.br = 1'b1;
                e.ill = 1'b0;
                case (fn3)
                    3'd0: begin e.data = a - b; e.tk = (a == b); end
                    3'd1: begin e.data = a - b; e.tk = (a != b); end
                    3'd4: begin
                        e.data = {31'd0, $signed(a) < $signed(b)};
                        e.tk = $signed(a) < $signed(b);
                    end
                    3'd5: begin
                        e.data = {31'd0, $signed(a) < $signed(b)};
                        e.tk = !($signed(a) < $signed(b));
                    end
                    3'd6: begin e.data = {31'd0, a < b}; e.tk = (a < b); end
                    3'd7: begin e.data = {31'd0, a < b}; e.tk = !(a < b); end
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        e.wb = !e.ill && !e.br && (e.rd != 5'd0);
        if (e.ill) begin
            e.data = '0;
            e.br = 1'b0;
            e.tk = 1'b0;
            e.wb = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_result", 32'd1, 32'd0);
                end else begin
                    got_e = sb.pop_front();
                    check("wb_data", wb_data, got_e.data);
                    check("wb_en", 32'(wb_en), 32'(got_e.wb));
                    check("rd_addr", 32'(rd_addr), 32'(got_e.rd));
                    check("is_branch", 32'(is_branch), 32'(got_e.br));
                    check("branch_taken", 32'(branch_taken), 32'(got_e.tk));
                    check("illegal", 32'(illegal), 32'(got_e.ill));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(ref_exec(instr, rs1_data, rs2_data));
        end
    end

    function automatic logic [31:0] r_ins(input logic [6:0] fn7,
                                          input logic [2:0] fn3,
                                          input logic [4:0] rd);
        return {fn7, 5'd2, 5'd1, fn3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm,
                                          input logic [2:0] fn3,
                                          input logic [4:0] rd);
        return {imm, 5'd1, fn3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] b_ins(input logic [2:0] fn3);
        return {7'd0, 5'd2, 5'd1, fn3, 5'd8, 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [2:0] fn3;
        logic [4:0] rd;
        logic [6:0] fn7;
        logic [11:0] imm;
        k = int'($urandom_range(0, 9));
        fn3 = 3'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        fn7 = 7'h00;
        if ((fn3 == 3'd0 || fn3 == 3'd5) && $urandom_range(0, 1) == 1)
            fn7 = 7'h20;
        if (k <= 3) begin
            if (k == 3 && $urandom_range(0, 3) == 0) fn7 = 7'($urandom);
            return r_ins(fn7, fn3, rd);
        end else if (k <= 6) begin
            if (fn3 == 3'd1 || fn3 == 3'd5) imm[11:5] = fn7;
            return i_ins(imm, fn3, rd);
        end else if (k == 7) begin
            return {7'($urandom), 5'd2, 5'd1, fn3, rd, 7'b1100011};
        end else if (k == 8) begin
            return {20'($urandom), rd, 7'b0110111};
        end
        return $urandom;
    endfunction

    task automatic issue(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        instr = i;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    bit rdone;
    logic [31:0] a_r, b_r;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu", {alu_in_1 | alu_in_2}, 32'd0);
        check("rst_ctl", {27'd0, alu_op, alu_cin}, 32'd0);
        check("rst_s2", {wb_data | {26'd0, wb_en, rd_addr}}, 32'd0);
        check("rst_flags", {29'd0, is_branch, branch_taken, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // reset while an ADD is in flight
        issue(r_ins(7'h00, 3'd0, 5'd5), 32'd1, 32'd2);
        rst = 1'b1;
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_alu", {alu_in_1 | alu_in_2}, 32'd0);
        check("midrst_ctl", {27'd0, alu_op, alu_cin}, 32'd0);
        check("midrst_s2", {wb_data | {26'd0, wb_en, rd_addr}}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);

        // SUB x3,x1,x2 : 5-7
        issue(r_ins(7'h20, 3'd0, 5'd3), 32'd5, 32'd7);
        check("sub_op", 32'(alu_op), 32'd0);
        check("sub_cin", 32'(alu_cin), 32'd1);
        @(posedge clk);
        #1;
        check("sub_latency", 32'(out_valid), 32'd1);
        check("sub_wb", wb_data, 32'hFFFF_FFFE);
        check("sub_wb_en", 32'(wb_en), 32'd1);
        check("sub_rd", 32'(rd_addr), 32'd3);

        // SRAI x4,x1,4
        issue(i_ins(12'h404, 3'd5, 5'd4), 32'h8000_0000, 32'd0);
        check("srai_op", 32'(alu_op), 32'd6);
        check("srai_cin", 32'(alu_cin), 32'd0);
        check("srai_shamt", 32'(alu_in_2[4:0]), 32'd4);
        wait_out();
        check("srai_wb", wb_data, 32'hF800_0000);

        // branches
        issue(b_ins(3'd6), 32'd1, 32'hFFFF_FFFF);
        check("bltu_op", 32'(alu_op), 32'd3);
        wait_out();
        check("bltu_br", {29'd0, is_branch, branch_taken, wb_en}, 32'd6);
        issue(b_ins(3'd0), 32'd9, 32'd9);
        check("beq_cin", 32'(alu_cin), 32'd1);
        wait_out();
        check("beq_taken", 32'(branch_taken), 32'd1);
        issue(b_ins(3'd1), 32'd9, 32'd9);
        wait_out();
        check("bne_taken", 32'(branch_taken), 32'd0);

        // edge decodes
        issue(r_ins(7'h00, 3'd0, 5'd0), 32'd4, 32'd4);
        wait_out();
        check("add_x0_wb_en", 32'(wb_en), 32'd0);
        issue(r_ins(7'h01, 3'd0, 5'd6), 32'd4, 32'd4);
        wait_out();
        check("bad_f7", {30'd0, illegal, wb_en}, 32'd2);
        issue({20'h12345, 5'd7, 7'b0110111}, 32'd0, 32'd0);
        wait_out();
        check("lui_wb", wb_data, 32'h1234_5000);

        // back-pressure: 4 ADDIs, consumer stalled
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(i_ins(12'd1, 3'd0, 5'd1), 32'h100, 32'd0);
        issue(i_ins(12'd2, 3'd0, 5'd2), 32'h200, 32'd0);
        instr = i_ins(12'd3, 3'd0, 5'd3);
        rs1_data = 32'h300;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_wb_hold", wb_data, 32'h101);
            check("bp_s1_hold", alu_in_1, 32'h200);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(i_ins(12'd3, 3'd0, 5'd3), 32'h300, 32'd0);
        issue(i_ins(12'd4, 3'd0, 5'd4), 32'h400, 32'd0);

        // random traffic with random consumer stalls
        rdone = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    a_r = $urandom;
                    b_r = ($urandom_range(0, 3) == 0) ? a_r : $urandom;
                    issue(rand_instr(), a_r, b_r);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;

        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
